// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared constants for the load/store unit
package lsu_pkg;

    // FSM state encoding
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    // RV32 load/store funct3 encodings
    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - store lane placement, load extraction and access checking
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic        write_i,
    input  logic [1:0]  offset_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rdata_i,
    output logic [31:0] store_data_o,
    output logic [31:0] store_mask_o,
    output logic [31:0] load_data_o,
    output logic        error_o
);

    logic [7:0]  sel_byte;
    logic [15:0] sel_half;
    logic        illegal;
    logic        misaligned;

    assign sel_byte = rdata_i[{offset_i, 3'b000} +: 8];
    assign sel_half = offset_i[1] ? rdata_i[31:16] : rdata_i[15:0];

    // Stores replicate the datum across the word; the mask picks the lane(s)
    always_comb begin
        store_data_o = 32'd0;
        store_mask_o = 32'd0;
        if (write_i) begin
            case (funct3_i)
                F3_B: begin
                    store_data_o = {4{wdata_i[7:0]}};
                    store_mask_o = 32'h0000_00FF << {offset_i, 3'b000};
                end
                F3_H: begin
                    store_data_o = {2{wdata_i[15:0]}};
                    store_mask_o = offset_i[1] ? 32'hFFFF_0000 : 32'h0000_FFFF;
                end
                F3_W: begin
                    store_data_o = wdata_i;
                    store_mask_o = 32'hFFFF_FFFF;
                end
                default: ;
            endcase
        end
    end

    // Loads pull the addressed byte/half out of the raw word and extend it
    always_comb begin
        load_data_o = 32'd0;
        case (funct3_i)
            F3_B:    load_data_o = {{24{sel_byte[7]}}, sel_byte};
            F3_BU:   load_data_o = {24'd0, sel_byte};
            F3_H:    load_data_o = {{16{sel_half[15]}}, sel_half};
            F3_HU:   load_data_o = {16'd0, sel_half};
            F3_W:    load_data_o = rdata_i;
            default: ;
        endcase
    end

    // Unsigned stores do not exist; 3, 6 and 7 are not load/store widths
    always_comb begin
        illegal    = (funct3_i == 3'd3) || (funct3_i[2:1] == 2'b11)
                   || (write_i && ((funct3_i == F3_BU) || (funct3_i == F3_HU)));
        misaligned = (((funct3_i == F3_H) || (funct3_i == F3_HU)) && offset_i[0])
                   || ((funct3_i == F3_W) && (offset_i != 2'b00));
        error_o    = illegal || misaligned;
    end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - single-outstanding load/store unit in front of a word memory
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int TIMEOUT = 0
)
(
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_address,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_error,
    input  logic        memory_ready,
    input  logic        memory_valid,
    input  logic [31:0] read_memory_data,
    output logic [31:0] read_memory_address,
    output logic [31:0] write_memory_data,
    output logic [31:0] write_memory_address,
    output logic [31:0] write_memory_mask,
    output logic        memory_command,
    output logic        memory_enable
);

    localparam logic [31:0] TIMEOUT_W = 32'(TIMEOUT);

    logic [1:0]  state_q,  state_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [1:0]  offset_q, offset_d;
    logic [31:0] addr_q,   addr_d;
    logic [31:0] wdata_q,  wdata_d;
    logic [31:0] mask_q,   mask_d;
    logic        cmd_q,    cmd_d;
    logic [31:0] rdata_q,  rdata_d;
    logic        err_q,    err_d;
    logic [31:0] cnt_q,    cnt_d;

    logic        idle;
    logic [2:0]  al_funct3;
    logic        al_write;
    logic [1:0]  al_offset;
    logic [31:0] al_store_data;
    logic [31:0] al_store_mask;
    logic [31:0] al_load_data;
    logic        al_error;

    assign idle = (state_q == ST_IDLE);

    // One aligner serves both phases: the live request while idle (store lanes,
    // error check) and the latched request afterwards (load extraction).
    assign al_funct3 = idle ? req_funct3         : funct3_q;
    assign al_write  = idle ? req_write          : cmd_q;
    assign al_offset = idle ? req_address[1:0]   : offset_q;

    lsu_align u_align (
        .funct3_i     (al_funct3),
        .write_i      (al_write),
        .offset_i     (al_offset),
        .wdata_i      (req_wdata),
        .rdata_i      (read_memory_data),
        .store_data_o (al_store_data),
        .store_mask_o (al_store_mask),
        .load_data_o  (al_load_data),
        .error_o      (al_error)
    );

    // Next-state logic: accept, issue, wait for completion or timeout, respond
    always_comb begin
        state_d  = state_q;
        funct3_d = funct3_q;
        offset_d = offset_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        mask_d   = mask_q;
        cmd_d    = cmd_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        cnt_d    = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    funct3_d = req_funct3;
                    offset_d = req_address[1:0];
                    addr_d   = {req_address[31:2], 2'b00};
                    wdata_d  = al_store_data;
                    mask_d   = al_store_mask;
                    cmd_d    = req_write;
                    cnt_d    = 32'd0;
                    rdata_d  = 32'd0;
                    if (al_error) begin
                        err_d   = 1'b1;
                        state_d = ST_RESP;
                    end else begin
                        err_d   = 1'b0;
                        state_d = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                if (memory_ready) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (memory_valid) begin
                    rdata_d = cmd_q ? 32'd0 : al_load_data;
                    state_d = ST_RESP;
                end else if ((TIMEOUT_W != 32'd0) && (cnt_q + 32'd1 == TIMEOUT_W)) begin
                    err_d   = 1'b1;
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            ST_RESP: begin
                rdata_d = 32'd0;
                err_d   = 1'b0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers; reset abandons any in-flight access
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            funct3_q <= 3'd0;
            offset_q <= 2'd0;
            addr_q   <= 32'd0;
            wdata_q  <= 32'd0;
            mask_q   <= 32'd0;
            cmd_q    <= 1'b0;
            rdata_q  <= 32'd0;
            err_q    <= 1'b0;
            cnt_q    <= 32'd0;
        end else begin
            state_q  <= state_d;
            funct3_q <= funct3_d;
            offset_q <= offset_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            mask_q   <= mask_d;
            cmd_q    <= cmd_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
            cnt_q    <= cnt_d;
        end
    end

    assign req_ready            = idle && !reset;
    assign memory_enable        = (state_q == ST_ISSUE) && memory_ready && !reset;
    assign resp_valid           = (state_q == ST_RESP) && !reset;
    assign resp_rdata           = rdata_q;
    assign resp_error           = err_q;
    assign read_memory_address  = addr_q;
    assign write_memory_address = addr_q;
    assign write_memory_data    = wdata_q;
    assign write_memory_mask    = mask_q;
    assign memory_command       = cmd_q;

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - randomized self-checking bench for load_store_unit
module tb_load_store_unit;

    localparam int TMO     = 4;
    localparam int N_DIR   = 10;
    localparam int N_TOTAL = 310;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, req_write;
    logic [2:0]  req_funct3;
    logic [31:0] req_address, req_wdata;
    logic        resp_valid, resp_error;
    logic [31:0] resp_rdata;
    logic        memory_ready, memory_valid;
    logic [31:0] read_memory_data, read_memory_address;
    logic [31:0] write_memory_data, write_memory_address, write_memory_mask;
    logic        memory_command, memory_enable;

    always #5 clk = ~clk;

    load_store_unit #(.TIMEOUT(TMO)) dut (
        .clk                  (clk),
        .reset                (reset),
        .req_valid            (req_valid),
        .req_ready            (req_ready),
        .req_write            (req_write),
        .req_funct3           (req_funct3),
        .req_address          (req_address),
        .req_wdata            (req_wdata),
        .resp_valid           (resp_valid),
        .resp_rdata           (resp_rdata),
        .resp_error           (resp_error),
        .memory_ready         (memory_ready),
        .memory_valid         (memory_valid),
        .read_memory_data     (read_memory_data),
        .read_memory_address  (read_memory_address),
        .write_memory_data    (write_memory_data),
        .write_memory_address (write_memory_address),
        .write_memory_mask    (write_memory_mask),
        .memory_command       (memory_command),
        .memory_enable        (memory_enable)
    );

    typedef struct {
        bit          w;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] wd;
        int          rdy;
        int          lat;
        bit          rst;
        bit          stray;
        bit          has_lit;
        logic [31:0] lrd;
        bit          lerr;
        int          llat;
        bit          has_bus;
        logic [31:0] lmask;
        logic [31:0] ldata;
        logic [31:0] lwaddr;
    } dir_t;

    dir_t dirs [N_DIR];

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;
    bit checking = 1'b1;

    logic [31:0] mem [16];

    int t_acc = -100, e_cyc = -100, val_cyc = -100, resp_cyc = -100;
    int busy_until = -1, rst_cyc = -100, stray_cyc = -100, zero_chk_cyc = 3;
    int win_lo = 0, win_hi = -1;
    bit p_err, p_cmd, p_err_resp;
    logic [31:0] p_addr, p_data, p_mask, p_rdata, p_word;
    bit has_lit, has_bus, lit_err;
    logic [31:0] lit_rdata, lit_mask, lit_data, lit_waddr;
    int lit_lat;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    // Reference model: works out the whole transaction (bus values, response
    // contents and the cycles at which things must happen) at accept time.
    task automatic new_txn(input bit w, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] wd, input int rdy, input int lat,
                           input bit rst_in_wait, input bit force_stray);
        int     o;
        int     nb;
        bit     legal;
        longint v;
        o     = int'(a[1:0]);
        nb    = 1;
        legal = 1'b1;
        case (f3)
            3'd0, 3'd4: nb = 1;
            3'd1, 3'd5: nb = 2;
            3'd2:       nb = 4;
            default:    legal = 1'b0;
        endcase
        if (w && f3 >= 3'd4) legal = 1'b0;
        p_err  = !legal || ((o % nb) != 0);
        p_addr = a & 32'hFFFF_FFFC;
        p_cmd  = w;
        p_data = 32'd0;
        p_mask = 32'd0;
        p_rdata = 32'd0;
        p_word = mem[a[5:2]];
        if (!p_err) begin
            if (w) begin
                for (int i = 0; i < 4; i++) begin
                    if (i / nb == o / nb) p_mask[8*i +: 8] = 8'hFF;
                    p_data[8*i +: 8] = wd[8*(i % nb) +: 8];
                end
                mem[a[5:2]] = (p_word & ~p_mask) | (p_data & p_mask);
            end else begin
                v = 0;
                for (int i = nb - 1; i >= 0; i--) v = v * 256 + longint'(p_word[8*(o+i) +: 8]);
                if (f3 < 3'd3 && v >= (longint'(1) << (8*nb - 1))) v = v - (longint'(1) << (8*nb));
                p_rdata = v[31:0];
            end
        end
        t_acc   = cyc;
        rst_cyc = -100;
        val_cyc = -100;
        win_lo  = 0;
        win_hi  = -1;
        if (p_err) begin
            e_cyc      = -100;
            resp_cyc   = cyc + 1;
            busy_until = resp_cyc;
            p_err_resp = 1'b1;
        end else begin
            e_cyc  = cyc + 1 + rdy;
            win_lo = e_cyc + 1;
            if (rst_in_wait) begin
                rst_cyc      = e_cyc + 1;
                resp_cyc     = -100;
                busy_until   = rst_cyc;
                win_hi       = rst_cyc;
                stray_cyc    = rst_cyc + 1;
                zero_chk_cyc = rst_cyc + 1;
            end else if (lat <= TMO) begin
                val_cyc    = e_cyc + lat;
                resp_cyc   = val_cyc + 1;
                busy_until = resp_cyc;
                win_hi     = resp_cyc - 1;
                p_err_resp = 1'b0;
            end else begin
                resp_cyc   = e_cyc + TMO + 1;
                busy_until = resp_cyc;
                win_hi     = resp_cyc - 1;
                p_err_resp = 1'b1;
                p_rdata    = 32'd0;
            end
        end
        if (force_stray) stray_cyc = busy_until + 1;
    endtask

    // Compare process: DUT outputs against the model on every cycle
    always @(negedge clk) begin
        if (checking && cyc >= 1) begin
            chk("req_ready", req_ready, !reset && (cyc > busy_until || cyc == t_acc));
            chk("memory_enable", memory_enable, cyc == e_cyc);
            chk("resp_valid", resp_valid, cyc == resp_cyc);
            if (cyc > t_acc && cyc <= busy_until) begin
                chk("write_memory_address", write_memory_address, p_addr);
                chk("read_memory_address", read_memory_address, p_addr);
            end
            if (!p_err && cyc > t_acc && cyc <= e_cyc) begin
                chk("memory_command", memory_command, p_cmd);
                chk("write_memory_data", write_memory_data, p_data);
                chk("write_memory_mask", write_memory_mask, p_mask);
            end
            if (cyc == e_cyc && has_bus) begin
                chk("lit_waddr", write_memory_address, lit_waddr);
                chk("lit_mask", write_memory_mask, lit_mask);
                chk("lit_wdata", write_memory_data, lit_data);
            end
            if (cyc == resp_cyc) begin
                chk("resp_rdata", resp_rdata, p_rdata);
                chk("resp_error", resp_error, p_err_resp);
                if (has_lit) begin
                    chk("lit_rdata", resp_rdata, lit_rdata);
                    chk("lit_error", resp_error, lit_err);
                end
            end
            if (resp_valid === 1'b1 && has_lit && cyc > t_acc)
                chk("lit_latency", cyc - t_acc, lit_lat);
            if (cyc == zero_chk_cyc) begin
                chk("zero_waddr", write_memory_address, 32'd0);
                chk("zero_raddr", read_memory_address, 32'd0);
                chk("zero_mask", write_memory_mask, 32'd0);
                chk("zero_wdata", write_memory_data, 32'd0);
                chk("zero_cmd", memory_command, 1'b0);
                chk("zero_rdata", resp_rdata, 32'd0);
            end
        end
    end

    // Stimulus: requests, memory handshake and reset, decided per cycle
    initial begin
        int n_issued;
        int gap;
        int rdy;
        int lat;
        n_issued = 0;
        gap = 0;
        reset = 1'b1;
        req_valid = 1'b0; req_write = 1'b0; req_funct3 = 3'd0;
        req_address = 32'd0; req_wdata = 32'd0;
        memory_ready = 1'b0; memory_valid = 1'b0; read_memory_data = 32'd0;
        for (int i = 0; i < 16; i++) mem[i] = $urandom;
        mem[0] = 32'h8001_F27F;

        dirs[0] = '{0, 3'd0, 32'h8000_0002, 32'd0, 0, 1, 0, 0, 1, 32'h0000_0001, 0, 3, 0, 32'd0, 32'd0, 32'd0};
        dirs[1] = '{0, 3'd1, 32'h8000_0002, 32'd0, 0, 1, 0, 0, 1, 32'hFFFF_8001, 0, 3, 0, 32'd0, 32'd0, 32'd0};
        dirs[2] = '{0, 3'd5, 32'h8000_0000, 32'd0, 0, 1, 0, 0, 1, 32'h0000_F27F, 0, 3, 0, 32'd0, 32'd0, 32'd0};
        dirs[3] = '{0, 3'd2, 32'h8000_0000, 32'd0, 0, 1, 0, 0, 1, 32'h8001_F27F, 0, 3, 0, 32'd0, 32'd0, 32'd0};
        dirs[4] = '{1, 3'd0, 32'h8000_0003, 32'h0000_00A5, 0, 1, 0, 0, 1, 32'd0, 0, 3,
                    1, 32'hFF00_0000, 32'hA5A5_A5A5, 32'h8000_0000};
        dirs[5] = '{0, 3'd2, 32'h8000_0006, 32'd0, 0, 1, 0, 0, 1, 32'd0, 1, 1, 0, 32'd0, 32'd0, 32'd0};
        dirs[6] = '{1, 3'd1, 32'h8000_0001, 32'h1234_5678, 0, 1, 0, 0, 1, 32'd0, 1, 1, 0, 32'd0, 32'd0, 32'd0};
        dirs[7] = '{0, 3'd2, 32'h8000_0004, 32'd0, 5, 1, 0, 0, 1, mem[1], 0, 8, 0, 32'd0, 32'd0, 32'd0};
        dirs[8] = '{0, 3'd2, 32'h8000_0008, 32'd0, 0, 99, 0, 1, 1, 32'd0, 1, 6, 0, 32'd0, 32'd0, 32'd0};
        dirs[9] = '{0, 3'd2, 32'h8000_000C, 32'd0, 0, 2, 1, 0, 0, 32'd0, 0, 0, 0, 32'd0, 32'd0, 32'd0};

        while (1) begin
            @(posedge clk);
            #1;
            reset = (cyc < 3) || (cyc == rst_cyc);
            if (cyc >= 3 && cyc > busy_until && gap == 0 && n_issued < N_TOTAL) begin
                req_valid = 1'b1;
                if (n_issued < N_DIR) begin
                    req_write   = dirs[n_issued].w;
                    req_funct3  = dirs[n_issued].f3;
                    req_address = dirs[n_issued].a;
                    req_wdata   = dirs[n_issued].wd;
                    has_lit   = dirs[n_issued].has_lit;
                    lit_rdata = dirs[n_issued].lrd;
                    lit_err   = dirs[n_issued].lerr;
                    lit_lat   = dirs[n_issued].llat;
                    has_bus   = dirs[n_issued].has_bus;
                    lit_mask  = dirs[n_issued].lmask;
                    lit_data  = dirs[n_issued].ldata;
                    lit_waddr = dirs[n_issued].lwaddr;
                    new_txn(dirs[n_issued].w, dirs[n_issued].f3, dirs[n_issued].a,
                            dirs[n_issued].wd, dirs[n_issued].rdy, dirs[n_issued].lat,
                            dirs[n_issued].rst, dirs[n_issued].stray);
                end else begin
                    req_write   = 1'($urandom_range(0, 1));
                    req_funct3  = 3'($urandom_range(0, 7));
                    req_address = 32'h8000_0000 | 32'($urandom_range(0, 63));
                    if ($urandom_range(0, 1) == 0) req_address[1:0] = 2'b00;
                    req_wdata   = $urandom;
                    rdy = $urandom_range(0, 3);
                    lat = ($urandom_range(0, 7) == 0) ? $urandom_range(5, 8) : $urandom_range(1, 4);
                    has_lit = 1'b0;
                    has_bus = 1'b0;
                    new_txn(req_write, req_funct3, req_address, req_wdata, rdy, lat,
                            $urandom_range(0, 39) == 0, $urandom_range(0, 7) == 0);
                end
                n_issued++;
                gap = $urandom_range(0, 2);
            end else begin
                if (cyc >= 3 && cyc > busy_until && gap > 0) gap--;
                req_valid   = (cyc >= 3 && cyc <= busy_until) ? 1'($urandom_range(0, 1)) : 1'b0;
                req_write   = 1'($urandom_range(0, 1));
                req_funct3  = 3'($urandom_range(0, 7));
                req_address = $urandom;
                req_wdata   = $urandom;
            end
            if (cyc > t_acc && cyc < e_cyc)  memory_ready = 1'b0;
            else if (cyc == e_cyc)           memory_ready = 1'b1;
            else                             memory_ready = 1'($urandom_range(0, 1));
            memory_valid = (cyc == val_cyc) || (cyc == stray_cyc)
                        || (!(cyc >= win_lo && cyc <= win_hi) && $urandom_range(0, 3) == 0);
            read_memory_data = (cyc == val_cyc) ? p_word : $urandom;
            if (n_issued == N_TOTAL && cyc > busy_until + 4) break;
        end
        @(posedge clk);
        #1;
        checking = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
